// File: rtl/i2s_mic_rx_if.sv
// ----------------------------------------------------------------------------
// i2s_mic_rx_if : sample stream from the I2S microphone receiver to the
//                 audio/PCM datapath.
//
//   s_data  [DATA_W] sample at FIFO head, MSB = first received bit
//   s_chan           channel of s_data (0 = left, 1 = right)
//   s_valid          head entry present
//   s_ready          consumer takes the head when s_valid & s_ready
//
// master = receiver side, slave = consumer side.
// ----------------------------------------------------------------------------
interface i2s_mic_rx_if #(
   parameter int DATA_W = 18
);
   logic [DATA_W-1:0] s_data;
   logic              s_chan;
   logic              s_valid;
   logic              s_ready;

   modport master (
      output s_data,
      output s_chan,
      output s_valid,
      input  s_ready
   );

   modport slave (
      input  s_data,
      input  s_chan,
      input  s_valid,
      output s_ready
   );
endinterface

// File: rtl/i2s_mic_rx.sv
// ----------------------------------------------------------------------------
// i2s_mic_rx : I2S MEMS-microphone receiver.
//
// Generates bclk/ws for one or two microphones sharing d_in, deserialises
// DATA_W-bit samples (MSB first, one-bit I2S delay after the ws edge), tags
// each with its channel and queues it in a FIFO_DEPTH-entry FIFO.
//
// Ports:
//   clk      system clock
//   reset    synchronous, active-high reset
//   enable   run capture; low holds the bus idle (FIFO is kept)
//   d_in     serial data from the microphone(s)
//   bclk     bit clock, period 2*CLK_DIV clk
//   ws       word select, 0 = left slot, 1 = right slot
//   overrun  sticky: a word was dropped on a full FIFO (reset clears it)
//   s        sample stream (i2s_mic_rx_if.master)
// ----------------------------------------------------------------------------
module i2s_mic_rx #(
   parameter int DATA_W     = 18,
   parameter int CLK_DIV    = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int STEREO     = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic          d_in,
   output logic          bclk,
   output logic          ws,
   output logic          overrun,
   i2s_mic_rx_if.master  s
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [4:0]       LAST_SLOT = 5'(DATA_W);
   localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

   // ------------------------------------------------------------------
   // Bus timing and deserialiser state
   // ------------------------------------------------------------------
   logic [DIV_W-1:0]  div_cnt_r;
   logic              bclk_r;
   logic [5:0]        bitpos_r;
   logic [DATA_W-1:0] shift_r;
   logic              push_r;
   logic              push_chan_r;

   logic              wrap_s;
   logic              rise_s;
   logic              fall_s;
   logic [4:0]        slot_s;
   logic              capture_s;
   logic              word_done_s;

   // Edge detection and slot decode from the divider/frame registers
   always_comb begin
      wrap_s      = (div_cnt_r == DIV_LAST);
      rise_s      = enable & wrap_s & ~bclk_r;
      fall_s      = enable & wrap_s & bclk_r;
      slot_s      = bitpos_r[4:0];
      capture_s   = 1'b0;
      word_done_s = 1'b0;
      if (rise_s && (slot_s != 5'd0) && (slot_s <= LAST_SLOT)) begin
         capture_s = 1'b1;
      end else begin
         capture_s = 1'b0;
      end
      // In mono mode the right slot is clocked but never queued.
      if (rise_s && (slot_s == LAST_SLOT) && ((STEREO != 0) || !bitpos_r[5])) begin
         word_done_s = 1'b1;
      end else begin
         word_done_s = 1'b0;
      end
   end

   // Divider, bit clock, frame position and shift register
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt_r   <= '0;
         bclk_r      <= 1'b0;
         bitpos_r    <= 6'd0;
         shift_r     <= '0;
         push_r      <= 1'b0;
         push_chan_r <= 1'b0;
      end else if (!enable) begin
         // Idle bus; a partially received word is thrown away.
         div_cnt_r   <= '0;
         bclk_r      <= 1'b0;
         bitpos_r    <= 6'd0;
         shift_r     <= '0;
         push_r      <= 1'b0;
         push_chan_r <= 1'b0;
      end else begin
         if (wrap_s) begin
            div_cnt_r <= '0;
            bclk_r    <= ~bclk_r;
         end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
         end
         // 6-bit counter wraps 63 -> 0 by itself.
         if (fall_s) begin
            bitpos_r <= bitpos_r + 6'd1;
         end
         // Truncating cast drops the oldest bit; also legal for DATA_W = 1.
         if (capture_s) begin
            shift_r <= DATA_W'({shift_r, d_in});
         end
         // The completed word sits in shift_r for a whole bclk period, so
         // the FIFO write is taken one clk after the LSB sampling edge.
         push_r <= word_done_s;
         if (word_done_s) begin
            push_chan_r <= bitpos_r[5];
         end
      end
   end

   assign bclk = bclk_r;
   assign ws   = bitpos_r[5];

   // ------------------------------------------------------------------
   // Output FIFO (registered storage, no bypass path)
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] mem_r      [FIFO_DEPTH];
   logic              chan_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [PTR_W:0]    count_r;
   logic              overrun_r;

   logic              full_s;
   logic              pop_s;
   logic              wr_s;
   logic              drop_s;

   // Push/pop arbitration; a pop frees the slot for a same-cycle push
   always_comb begin
      full_s = (count_r == FULL_CNT);
      pop_s  = (count_r != '0) & s.s_ready;
      wr_s   = push_r & (~full_s | pop_s);
      drop_s = push_r & full_s & ~pop_s;
   end

   // FIFO storage, pointers, occupancy and sticky overrun
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i]      <= '0;
            chan_mem_r[i] <= 1'b0;
         end
         wr_ptr_r  <= '0;
         rd_ptr_r  <= '0;
         count_r   <= '0;
         overrun_r <= 1'b0;
      end else begin
         if (wr_s) begin
            mem_r[wr_ptr_r]      <= shift_r;
            chan_mem_r[wr_ptr_r] <= push_chan_r;
            wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({wr_s, pop_s})
            2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
            2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
            default: count_r <= count_r;
         endcase
         overrun_r <= overrun_r | drop_s;
      end
   end

   assign s.s_data  = mem_r[rd_ptr_r];
   assign s.s_chan  = chan_mem_r[rd_ptr_r];
   assign s.s_valid = (count_r != '0);
   assign overrun   = overrun_r;

endmodule

// File: tb/tb_i2s_mic_rx.sv
// ----------------------------------------------------------------------------
// tb_i2s_mic_rx : self-checking bench for i2s_mic_rx.
// A stereo instance (dut) and a mono instance (dut2) run from one clock.
// Each microphone is modelled from the I2S frame rules: it counts bclk
// falls since enable, and drives the MSB-first word for the current slot
// with a one-bit delay, random filler elsewhere.
// ----------------------------------------------------------------------------
module tb_i2s_mic_rx;
   localparam int DATA_W     = 18;
   localparam int CLK_DIV    = 2;
   localparam int FIFO_DEPTH = 4;
   localparam logic [31:0] MASK = (32'd1 << DATA_W) - 32'd1;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              chan;
   } beat_t;

   logic clk = 1'b0;
   logic reset, enable, d_in, bclk, ws, overrun;
   logic en2, d2, bclk2, ws2, ov2;

   i2s_mic_rx_if #(.DATA_W(DATA_W)) sif ();
   i2s_mic_rx_if #(.DATA_W(DATA_W)) sif2 ();

   i2s_mic_rx #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .STEREO(1)) dut (
      .clk(clk), .reset(reset), .enable(enable), .d_in(d_in),
      .bclk(bclk), .ws(ws), .overrun(overrun), .s(sif));

   i2s_mic_rx #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .STEREO(0)) dut2 (
      .clk(clk), .reset(reset), .enable(en2), .d_in(d2),
      .bclk(bclk2), .ws(ws2), .overrun(ov2), .s(sif2));

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_fail = 0;
   logic [31:0] lw [8];
   logic [31:0] rw [8];
   logic [31:0] lw2 [8];
   logic [31:0] rw2 [8];
   beat_t rx_q [$];
   beat_t rx2_q [$];
   int fc1 = 0, fc2 = 0;
   logic pb1 = 1'b0, pb2 = 1'b0;

   // Bit a microphone puts on the line for the given number of bclk falls.
   function automatic logic mic_bit(int fcnt, logic [31:0] lword, logic [31:0] rword);
      int bp = fcnt % 64;
      int slot = bp % 32;
      logic [31:0] w = (bp >= 32) ? rword : lword;
      if (slot >= 1 && slot <= DATA_W) return w[DATA_W - slot];
      return 1'($urandom);
   endfunction

   // Microphone models and stream consumers, away from the active edge
   always @(negedge clk) begin
      if (enable !== 1'b1) fc1 = 0;
      else if (pb1 && !bclk) fc1++;
      pb1 = bclk;
      d_in = mic_bit(fc1, lw[(fc1 / 64) % 8], rw[(fc1 / 64) % 8]);
      if (en2 !== 1'b1) fc2 = 0;
      else if (pb2 && !bclk2) fc2++;
      pb2 = bclk2;
      d2 = mic_bit(fc2, lw2[(fc2 / 64) % 8], rw2[(fc2 / 64) % 8]);
      if (sif.s_valid === 1'b1 && sif.s_ready === 1'b1) rx_q.push_back('{sif.s_data, sif.s_chan});
      if (sif2.s_valid === 1'b1 && sif2.s_ready === 1'b1) rx2_q.push_back('{sif2.s_data, sif2.s_chan});
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_drain();
      enable = 1'b0;
      sif.s_ready = 1'b1;
      repeat (20) cyc();
      rx_q.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; en2 = 1'b0;
      sif.s_ready = 1'b0; sif2.s_ready = 1'b1;
      cyc(); cyc();
      reset = 1'b0;
      for (int i = 0; i < 100; i++) begin
         cyc();
         n_cmp++;
         if ({bclk, ws, sif.s_valid, overrun, sif.s_chan} !== 5'b0 || sif.s_data !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: cyc %0d got bclk/ws/valid/ovr/chan=%b data=%h, expected all 0",
                     i, {bclk, ws, sif.s_valid, overrun, sif.s_chan}, sif.s_data);
         end
         n_cmp++;
         if ({bclk2, ws2, sif2.s_valid, ov2} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_idle_mono: cyc %0d got %b expected 0000", i, {bclk2, ws2, sif2.s_valid, ov2});
         end
      end
   endtask

   task automatic test_timing();
      logic eb, ew;
      idle_drain();
      enable = 1'b1;
      for (int n = 1; n <= 300; n++) begin
         cyc();
         eb = ((n % (2 * CLK_DIV)) >= CLK_DIV);
         ew = (((n / (2 * CLK_DIV)) % 64) >= 32);
         n_cmp++;
         if (bclk !== eb || ws !== ew) begin
            n_fail++;
            $display("FAIL timing: clk %0d got bclk=%b ws=%b expected bclk=%b ws=%b", n, bclk, ws, eb, ew);
         end
      end
      enable = 1'b0;
   endtask

   task automatic test_stereo();
      int first = -1;
      idle_drain();
      lw[0] = 32'h0002A5C3;
      rw[0] = 32'h00015A3C;
      enable = 1'b1;
      for (int n = 1; n <= 260; n++) begin
         cyc();
         if (sif.s_valid === 1'b1 && first < 0) first = n;
      end
      enable = 1'b0;
      cyc();
      n_cmp++;
      if (first != 75) begin
         n_fail++;
         $display("FAIL stereo_valid_latency: s_valid rose at clk %0d expected 75", first);
      end
      n_cmp++;
      if (rx_q.size() != 2) begin
         n_fail++;
         $display("FAIL stereo_count: got %0d beats expected 2", rx_q.size());
      end else begin
         n_cmp++;
         if (rx_q[0].data !== 18'h2A5C3 || rx_q[0].chan !== 1'b0) begin
            n_fail++;
            $display("FAIL stereo_left: got %h/%b expected 2a5c3/0", rx_q[0].data, rx_q[0].chan);
         end
         n_cmp++;
         if (rx_q[1].data !== 18'h15A3C || rx_q[1].chan !== 1'b1) begin
            n_fail++;
            $display("FAIL stereo_right: got %h/%b expected 15a3c/1", rx_q[1].data, rx_q[1].chan);
         end
      end
   endtask

   task automatic test_random_stream();
      beat_t exp_q [$];
      idle_drain();
      for (int f = 0; f < 8; f++) begin
         lw[f] = $urandom & MASK;
         rw[f] = $urandom & MASK;
      end
      for (int f = 0; f < 4; f++) begin
         exp_q.push_back('{lw[f][DATA_W-1:0], 1'b0});
         exp_q.push_back('{rw[f][DATA_W-1:0], 1'b1});
      end
      enable = 1'b1;
      for (int n = 1; n <= 1060; n++) begin
         sif.s_ready = 1'($urandom_range(0, 1));
         cyc();
      end
      enable = 1'b0;
      sif.s_ready = 1'b1;
      repeat (20) cyc();
      n_cmp++;
      if (rx_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL random_count: got %0d beats expected %0d", rx_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (rx_q[i].data !== exp_q[i].data || rx_q[i].chan !== exp_q[i].chan) begin
               n_fail++;
               $display("FAIL random_beat%0d: got %h/%b expected %h/%b", i,
                        rx_q[i].data, rx_q[i].chan, exp_q[i].data, exp_q[i].chan);
            end
         end
      end
      n_cmp++;
      if (overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL random_overrun: got %b expected 0", overrun);
      end
   endtask

   task automatic test_backpressure();
      logic [DATA_W-1:0] e [4];
      idle_drain();
      for (int f = 0; f < 3; f++) begin
         lw[f] = $urandom & MASK;
         rw[f] = $urandom & MASK;
      end
      e[0] = lw[0][DATA_W-1:0]; e[1] = rw[0][DATA_W-1:0];
      e[2] = lw[1][DATA_W-1:0]; e[3] = rw[1][DATA_W-1:0];
      sif.s_ready = 1'b0;
      enable = 1'b1;
      for (int n = 1; n <= 770; n++) begin
         cyc();
         if (n == 100 || n == 450) begin
            n_cmp++;
            if (sif.s_valid !== 1'b1 || sif.s_data !== e[0] || sif.s_chan !== 1'b0) begin
               n_fail++;
               $display("FAIL bp_hold: clk %0d got v=%b %h/%b expected v=1 %h/0",
                        n, sif.s_valid, sif.s_data, sif.s_chan, e[0]);
            end
         end
         if (n == 586 || n == 587) begin
            n_cmp++;
            if (overrun !== (n == 587)) begin
               n_fail++;
               $display("FAIL bp_overrun_edge: clk %0d got %b expected %b", n, overrun, (n == 587));
            end
         end
      end
      enable = 1'b0;
      repeat (5) cyc();
      sif.s_ready = 1'b1;
      repeat (12) cyc();
      n_cmp++;
      if (rx_q.size() != 4) begin
         n_fail++;
         $display("FAIL bp_count: got %0d beats expected 4", rx_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rx_q[i].data !== e[i] || rx_q[i].chan !== 1'(i % 2)) begin
               n_fail++;
               $display("FAIL bp_beat%0d: got %h/%b expected %h/%0d", i, rx_q[i].data, rx_q[i].chan, e[i], i % 2);
            end
         end
      end
      n_cmp++;
      if (overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_sticky: overrun got %b expected 1", overrun);
      end
   endtask

   task automatic test_mid_reset();
      idle_drain();
      enable = 1'b1;
      repeat (73) cyc();
      reset = 1'b1;
      cyc();
      n_cmp++;
      if ({bclk, ws, sif.s_valid, overrun, sif.s_chan} !== 5'b0 || sif.s_data !== '0) begin
         n_fail++;
         $display("FAIL mid_reset: got bclk/ws/valid/ovr/chan=%b data=%h expected all 0",
                  {bclk, ws, sif.s_valid, overrun, sif.s_chan}, sif.s_data);
      end
      reset = 1'b0;
      enable = 1'b0;
      repeat (10) cyc();
      n_cmp++;
      if (sif.s_valid !== 1'b0 || rx_q.size() != 0 || overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_nopush: got valid=%b beats=%0d ovr=%b expected 0/0/0",
                  sif.s_valid, rx_q.size(), overrun);
      end
   endtask

   task automatic test_full_pop();
      logic [DATA_W-1:0] e [5];
      reset = 1'b1; enable = 1'b0;
      cyc();
      reset = 1'b0;
      cyc();
      rx_q.delete();
      for (int f = 0; f < 3; f++) begin
         lw[f] = $urandom & MASK;
         rw[f] = $urandom & MASK;
      end
      e[0] = lw[0][DATA_W-1:0]; e[1] = rw[0][DATA_W-1:0];
      e[2] = lw[1][DATA_W-1:0]; e[3] = rw[1][DATA_W-1:0];
      e[4] = lw[2][DATA_W-1:0];
      sif.s_ready = 1'b0;
      enable = 1'b1;
      for (int n = 1; n <= 600; n++) begin
         cyc();
         if (n == 586) sif.s_ready = 1'b1;
         if (n == 587) begin
            sif.s_ready = 1'b0;
            n_cmp++;
            if (overrun !== 1'b0) begin
               n_fail++;
               $display("FAIL full_pop_overrun: got %b expected 0", overrun);
            end
         end
      end
      enable = 1'b0;
      cyc();
      sif.s_ready = 1'b1;
      repeat (12) cyc();
      n_cmp++;
      if (rx_q.size() != 5) begin
         n_fail++;
         $display("FAIL full_pop_count: got %0d beats expected 5", rx_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (rx_q[i].data !== e[i] || rx_q[i].chan !== 1'(i % 2)) begin
               n_fail++;
               $display("FAIL full_pop_beat%0d: got %h/%b expected %h/%0d", i, rx_q[i].data, rx_q[i].chan, e[i], i % 2);
            end
         end
      end
      n_cmp++;
      if (overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL full_pop_final_overrun: got %b expected 0", overrun);
      end
   endtask

   task automatic test_mono_abort();
      logic [DATA_W-1:0] c, d;
      for (int f = 0; f < 8; f++) begin
         lw2[f] = $urandom & MASK;
         rw2[f] = $urandom & MASK;
      end
      rx2_q.delete();
      en2 = 1'b1;
      repeat (38) cyc();
      en2 = 1'b0;
      cyc();
      n_cmp++;
      if (bclk2 !== 1'b0 || ws2 !== 1'b0) begin
         n_fail++;
         $display("FAIL mono_abort_idle: got bclk=%b ws=%b expected 0/0", bclk2, ws2);
      end
      repeat (10) cyc();
      n_cmp++;
      if (rx2_q.size() != 0) begin
         n_fail++;
         $display("FAIL mono_abort_nopush: got %0d beats expected 0", rx2_q.size());
      end
      lw2[0] = $urandom & MASK;
      lw2[1] = $urandom & MASK;
      c = lw2[0][DATA_W-1:0];
      d = lw2[1][DATA_W-1:0];
      en2 = 1'b1;
      for (int n = 1; n <= 540; n++) begin
         cyc();
         if (n <= 2) begin
            n_cmp++;
            if (ws2 !== 1'b0 || bclk2 !== (n == 2)) begin
               n_fail++;
               $display("FAIL mono_restart: clk %0d got bclk=%b ws=%b expected bclk=%b ws=0", n, bclk2, ws2, (n == 2));
            end
         end
      end
      en2 = 1'b0;
      repeat (5) cyc();
      n_cmp++;
      if (rx2_q.size() != 2) begin
         n_fail++;
         $display("FAIL mono_count: got %0d beats expected 2", rx2_q.size());
      end else begin
         n_cmp++;
         if (rx2_q[0].data !== c || rx2_q[0].chan !== 1'b0 || rx2_q[1].data !== d || rx2_q[1].chan !== 1'b0) begin
            n_fail++;
            $display("FAIL mono_words: got %h/%b %h/%b expected %h/0 %h/0",
                     rx2_q[0].data, rx2_q[0].chan, rx2_q[1].data, rx2_q[1].chan, c, d);
         end
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; en2 = 1'b0; d_in = 1'b0; d2 = 1'b0;
      sif.s_ready = 1'b0; sif2.s_ready = 1'b1;
      for (int f = 0; f < 8; f++) begin
         lw[f] = 32'd0; rw[f] = 32'd0; lw2[f] = 32'd0; rw2[f] = 32'd0;
      end
      test_reset();
      test_timing();
      test_stereo();
      test_random_stream();
      test_backpressure();
      test_mid_reset();
      test_full_pop();
      test_mono_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
